// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// Holds the fetch PC, issues req/ack fetches to instruction memory and hands
// the returned words to decode through a two-entry buffer (output slot + skid).
// Optional build macro FETCH_ALIGN_CHECK_EN: when defined, a redirect to a
// target that is not word aligned raises fetch_err and parks the unit in IDLE;
// when undefined, the low two bits of the redirect target are cleared.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_out,
    output logic        fetch_err
);

    // Wait counter is at least 4 bits wide, wider if MAX_WAIT needs it.
    localparam int unsigned CNT_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state_r,      state_nxt_s;
    logic [31:0]      pc_r,         pc_nxt_s;
    logic             slot_valid_r, slot_valid_nxt_s;
    logic [31:0]      slot_data_r,  slot_data_nxt_s;
    logic [31:0]      slot_pc_r,    slot_pc_nxt_s;
    logic [31:0]      skid_data_r,  skid_data_nxt_s;
    logic [31:0]      skid_pc_r,    skid_pc_nxt_s;
    logic [CNT_W-1:0] cnt_r,        cnt_nxt_s;
    logic             err_r,        err_nxt_s;

    logic             imem_req_s;
    logic             fire_s;
    logic             drain_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [31:0]      redir_pc_s;
    logic             misalign_s;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_pc_s = redirect_pc;
    assign misalign_s = |redirect_pc[1:0];
`else
    assign redir_pc_s = redirect_pc & 32'hFFFF_FFFC;
    assign misalign_s = 1'b0;
`endif

    // Request is only raised while fetching and not stalled; memory sees the PC directly.
    assign imem_req_s = (state_r == ST_FETCH) && !stall;
    assign fire_s     = imem_req_s && imem_ack;
    assign drain_s    = slot_valid_r && instr_ready;
    assign cnt_inc_s  = cnt_r + CNT_ONE;

    assign imem_req    = imem_req_s;
    assign imem_addr   = pc_r;
    assign pc_out      = pc_r;
    assign instr_valid = slot_valid_r;
    assign instr_out   = slot_data_r;
    assign instr_pc    = slot_pc_r;
    assign fetch_err   = err_r;

    // Next-state logic: redirect first, then per-state fetch/buffer sequencing.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        slot_valid_nxt_s = slot_valid_r;
        slot_data_nxt_s  = slot_data_r;
        slot_pc_nxt_s    = slot_pc_r;
        skid_data_nxt_s  = skid_data_r;
        skid_pc_nxt_s    = skid_pc_r;
        cnt_nxt_s        = cnt_r;
        err_nxt_s        = err_r;
        if (redirect) begin
            pc_nxt_s         = redir_pc_s;
            slot_valid_nxt_s = 1'b0;
            cnt_nxt_s        = CNT_ZERO;
            if (misalign_s) begin
                err_nxt_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end else begin
                err_nxt_s   = 1'b0;
                state_nxt_s = stall ? ST_IDLE : ST_FETCH;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (drain_s) begin
                        slot_valid_nxt_s = 1'b0;
                    end else begin
                        slot_valid_nxt_s = slot_valid_r;
                    end
                    if (!stall && !err_r) begin
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (fire_s) begin
                        pc_nxt_s  = pc_r + 32'd4;
                        cnt_nxt_s = CNT_ZERO;
                        // Slot free or emptying this edge: word goes straight out, no bubble.
                        if (!slot_valid_r || instr_ready) begin
                            slot_valid_nxt_s = 1'b1;
                            slot_data_nxt_s  = imem_rdata;
                            slot_pc_nxt_s    = pc_r;
                            state_nxt_s      = ST_FETCH;
                        end else begin
                            skid_data_nxt_s = imem_rdata;
                            skid_pc_nxt_s   = pc_r;
                            state_nxt_s     = ST_HOLD;
                        end
                    end else begin
                        if (drain_s) begin
                            slot_valid_nxt_s = 1'b0;
                        end else begin
                            slot_valid_nxt_s = slot_valid_r;
                        end
                        if (imem_req_s) begin
                            cnt_nxt_s = cnt_inc_s;
                            if (cnt_inc_s == WAIT_LIMIT) begin
                                err_nxt_s   = 1'b1;
                                state_nxt_s = ST_IDLE;
                            end else begin
                                state_nxt_s = ST_FETCH;
                            end
                        end else begin
                            cnt_nxt_s = cnt_r;
                        end
                    end
                end
                ST_HOLD: begin
                    // Both entries full: wait for decode to take the slot, then shift skid in.
                    if (instr_ready) begin
                        slot_data_nxt_s = skid_data_r;
                        slot_pc_nxt_s   = skid_pc_r;
                        state_nxt_s     = stall ? ST_IDLE : ST_FETCH;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    slot_valid_nxt_s = 1'b0;
                    state_nxt_s      = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            slot_valid_r <= 1'b0;
            slot_data_r  <= 32'h0000_0000;
            slot_pc_r    <= 32'h0000_0000;
            skid_data_r  <= 32'h0000_0000;
            skid_pc_r    <= 32'h0000_0000;
            cnt_r        <= CNT_ZERO;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            slot_valid_r <= slot_valid_nxt_s;
            slot_data_r  <= slot_data_nxt_s;
            slot_pc_r    <= slot_pc_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
            skid_pc_r    <= skid_pc_nxt_s;
            cnt_r        <= cnt_nxt_s;
            err_r        <= err_nxt_s;
        end
    end

endmodule
